// File: rtl/branch_adder_arbiter.sv
// Round-robin arbiter sharing one branch-target adder between EX resolution (0) and IF prefetch (1).
// Optional grant counters are enabled by defining BR_ARB_GRANT_CNT_EN.
module branch_adder_arbiter #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2*W-1:0]   rsp_sum
`ifdef BR_ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] gnt0_cnt,
    output logic [CNT_W-1:0] gnt1_cnt
`endif
);

    // Zero-extended add so the carry lands in bit W and is never lost.
    function automatic logic [2*W-1:0] add_ext(input logic [W-1:0] a, input logic [W-1:0] b);
        add_ext = {{W{1'b0}}, a} + {{W{1'b0}}, b};
    endfunction

    logic           last_grant_r;
    logic           rsp_valid_r;
    logic           rsp_id_r;
    logic [2*W-1:0] rsp_sum_r;

    logic           grant0_s;
    logic           grant1_s;
    logic           can_accept_s;
    logic           accept_s;
    logic [W-1:0]   sel_a_s;
    logic [W-1:0]   sel_b_s;

    // Round-robin grant: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0_s = last_grant_r;
            grant1_s = ~last_grant_r;
        end else if (req0_valid) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Handshake qualification and operand steering into the shared adder.
    always_comb begin
        can_accept_s = ~rsp_valid_r | rsp_ready;
        accept_s     = (grant0_s | grant1_s) & can_accept_s & ~flush & rst_n;
        req0_ready   = grant0_s & can_accept_s & ~flush & rst_n;
        req1_ready   = grant1_s & can_accept_s & ~flush & rst_n;
        if (grant1_s) begin
            sel_a_s = req1_a;
            sel_b_s = req1_b;
        end else begin
            sel_a_s = req0_a;
            sel_b_s = req0_b;
        end
    end

    // Result slot: flush beats everything, then a new transfer, then a plain drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_sum_r    <= {(2*W){1'b0}};
            last_grant_r <= 1'b1;
        end else if (flush) begin
            rsp_valid_r  <= 1'b0;
        end else if (accept_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= grant1_s;
            rsp_sum_r    <= add_ext(sel_a_s, sel_b_s);
            last_grant_r <= grant1_s;
        end else if (rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end else begin
            rsp_valid_r  <= rsp_valid_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_sum   = rsp_sum_r;

`ifdef BR_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] gnt0_cnt_r;
    logic [CNT_W-1:0] gnt1_cnt_r;

    // Saturating per-requester grant counters; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_cnt_r <= {CNT_W{1'b0}};
            gnt1_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s && grant0_s && (gnt0_cnt_r != {CNT_W{1'b1}})) begin
                gnt0_cnt_r <= gnt0_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (accept_s && grant1_s && (gnt1_cnt_r != {CNT_W{1'b1}})) begin
                gnt1_cnt_r <= gnt1_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign gnt0_cnt = gnt0_cnt_r;
    assign gnt1_cnt = gnt1_cnt_r;
`endif

endmodule

// File: tb/tb_branch_adder_arbiter.sv
// Directed self-checking bench for branch_adder_arbiter (counter checks when BR_ARB_GRANT_CNT_EN is defined).
module tb_branch_adder_arbiter;

    localparam int W     = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             req0_valid;
    logic             req0_ready;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [2*W-1:0]   rsp_sum;
`ifdef BR_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] gnt0_cnt;
    logic [CNT_W-1:0] gnt1_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    branch_adder_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum)
`ifdef BR_ARB_GRANT_CNT_EN
        ,
        .gnt0_cnt   (gnt0_cnt),
        .gnt1_cnt   (gnt1_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        exp_id;
        logic [63:0] exp_sum;

        rst_n      = 1'b0;
        flush      = 1'b0;
        req0_valid = 1'b1;
        req0_a     = 32'h0;
        req0_b     = 32'h0;
        req1_valid = 1'b0;
        req1_a     = 32'h0;
        req1_b     = 32'h0;
        rsp_ready  = 1'b0;

        // In reset: everything idle, ready held low even with a request present
        #3;
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_sum", rsp_sum, 64'd0);
        req0_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", {63'd0, rsp_valid}, 64'd0);
            chk("idle_ready0", {63'd0, req0_ready}, 64'd0);
            chk("idle_ready1", {63'd0, req1_ready}, 64'd0);
            chk("idle_sum", rsp_sum, 64'd0);
        end

        // Single request from requester 0
        req0_valid = 1'b1;
        req0_a     = 32'h0000_1000;
        req0_b     = 32'h0000_0040;
        rsp_ready  = 1'b1;
        #1;
        chk("r0_ready", {63'd0, req0_ready}, 64'd1);
        chk("r0_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        req0_valid = 1'b0;
        chk("r0_valid", {63'd0, rsp_valid}, 64'd1);
        chk("r0_id", {63'd0, rsp_id}, 64'd0);
        chk("r0_sum", rsp_sum, 64'h1040);

        // Async reset with the slot full clears it without a clock edge
        rst_n = 1'b0;
        #1;
        chk("async_valid", {63'd0, rsp_valid}, 64'd0);
        chk("async_sum", rsp_sum, 64'd0);
        rst_n = 1'b1;
        #1;

        // Fairness: both valid every cycle, results alternate starting with 0
        req0_valid = 1'b1;
        req0_a     = 32'd1;
        req0_b     = 32'd1;
        req1_valid = 1'b1;
        req1_a     = 32'd2;
        req1_b     = 32'd2;
        #1;
        chk("rr_first_r0", {63'd0, req0_ready}, 64'd1);
        chk("rr_first_r1", {63'd0, req1_ready}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            exp_id  = i[0];
            exp_sum = exp_id ? 64'd4 : 64'd2;
            tick();
            chk("rr_valid", {63'd0, rsp_valid}, 64'd1);
            chk("rr_id", {63'd0, rsp_id}, {63'd0, exp_id});
            chk("rr_sum", rsp_sum, exp_sum);
            chk("rr_next_r0", {63'd0, req0_ready}, {63'd0, exp_id});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("rr_drain", {63'd0, rsp_valid}, 64'd0);

        // Carry out of bit W-1 plus backpressure hold
        req0_valid = 1'b1;
        req0_a     = 32'hFFFF_FFFF;
        req0_b     = 32'h0000_0001;
        rsp_ready  = 1'b0;
        #1;
        chk("cy_ready", {63'd0, req0_ready}, 64'd1);
        tick();
        req0_a = 32'd5;
        req0_b = 32'd6;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_sum", rsp_sum, 64'h0000_0001_0000_0000);
            chk("hold_id", {63'd0, rsp_id}, 64'd0);
            chk("hold_ready0", {63'd0, req0_ready}, 64'd0);
            if (i < 2) tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("rel_ready0", {63'd0, req0_ready}, 64'd1);
        tick();
        req0_valid = 1'b0;
        chk("b2b_valid", {63'd0, rsp_valid}, 64'd1);
        chk("b2b_sum", rsp_sum, 64'd11);
        tick();
        chk("b2b_drain", {63'd0, rsp_valid}, 64'd0);

        // Flush discards a full slot and blocks a pending grant for one cycle
        req0_valid = 1'b1;
        req0_a     = 32'd7;
        req0_b     = 32'd8;
        tick();
        req0_valid = 1'b0;
        chk("fl_full", rsp_sum, 64'd15);
        flush      = 1'b1;
        req1_valid = 1'b1;
        req1_a     = 32'h100;
        req1_b     = 32'h23;
        #1;
        chk("fl_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        chk("fl_valid", {63'd0, rsp_valid}, 64'd0);
        flush = 1'b0;
        #1;
        chk("post_fl_ready1", {63'd0, req1_ready}, 64'd1);
        tick();
        req1_valid = 1'b0;
        chk("post_fl_valid", {63'd0, rsp_valid}, 64'd1);
        chk("post_fl_id", {63'd0, rsp_id}, 64'd1);
        chk("post_fl_sum", rsp_sum, 64'h123);
        tick();

        // Grant counting, flush survival and async reset mid-transfer
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        req0_valid = 1'b1;
        req0_a     = 32'd3;
        req0_b     = 32'd4;
        for (int i = 0; i < 3; i++) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        req1_valid = 1'b0;
        chk("cnt_last_id", {63'd0, rsp_id}, 64'd1);
`ifdef BR_ARB_GRANT_CNT_EN
        chk("cnt0", {48'd0, gnt0_cnt}, 64'd3);
        chk("cnt1", {48'd0, gnt1_cnt}, 64'd2);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("cnt_fl_valid", {63'd0, rsp_valid}, 64'd0);
`ifdef BR_ARB_GRANT_CNT_EN
        chk("cnt0_fl", {48'd0, gnt0_cnt}, 64'd3);
        chk("cnt1_fl", {48'd0, gnt1_cnt}, 64'd2);
`endif
        req0_valid = 1'b1;
        tick();
        chk("mid_valid", {63'd0, rsp_valid}, 64'd1);
        chk("mid_sum", rsp_sum, 64'd7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
`ifdef BR_ARB_GRANT_CNT_EN
        chk("cnt0_rst", {48'd0, gnt0_cnt}, 64'd0);
        chk("cnt1_rst", {48'd0, gnt1_cnt}, 64'd0);
`endif
        req0_valid = 1'b0;
        rst_n      = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_adder_arbiter.md
Name: branch_adder_arbiter

Overview:
- Shares the single branch-target address adder between two requesters:
  - requester 0: EX-stage branch/jump resolution.
  - requester 1: IF-stage PC-relative prefetch.
- Round-robin arbitration, valid/ready handshakes on both sides, one registered result slot between adder and consumer.
- Sits between the requesters and the fetch/PC-select logic; owns the adder instance and sequences which operands drive it each cycle.

Parameters:
- W, 32, operand width of each adder input.
- CNT_W, 16, width of optional grant counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; discards held result.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a  in  W  requester 0 base (PC or register).
- req0_b  in  W  requester 0 offset.
- req1_valid  in  1  requester 1 has operands.
- req1_ready  out  1  requester 1 operands accepted this cycle.
- req1_a  in  W  requester 1 base.
- req1_b  in  W  requester 1 offset.
- rsp_valid  out  1  result slot full.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  which requester owns rsp_sum.
- rsp_sum  out  2*W  zero-extended sum.
- gnt0_cnt  out  CNT_W  grants to requester 0 (feature only).
- gnt1_cnt  out  CNT_W  grants to requester 1 (feature only).

Behaviour:
Reset
- rst_n low, asynchronous: rsp_valid=0, rsp_id=0, rsp_sum=0, last_grant=1 (so requester 0 wins first), counters=0.
- req*_ready are combinational and therefore read 0 during reset.

Slot states
- EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY | (FULL & rsp_ready).

Arbitration (combinational)
- Only one requester valid: grant it.
- Both valid: grant the one that is not last_grant.
- reqN_ready = grantN & can_accept & ~flush.

Transfer
- On a grant with can_accept:
  - rsp_sum <= {W'b0, a} + {W'b0, b}; bit W is the carry, bits [2W-1:W+1] are always 0.
  - rsp_id <= granted index; rsp_valid <= 1; last_grant <= granted index.
- Latency is exactly 1 cycle from the accepting edge to rsp_valid.

Slot transitions
- FULL & rsp_ready & no grant -> EMPTY.
- FULL & rsp_ready & grant -> FULL with the new result. Back-to-back throughput is 1 per cycle.
- FULL & ~rsp_ready -> hold rsp_sum and rsp_id stable; both req*_ready=0.

Arithmetic boundary
- a=FFFFFFFF, b=00000001 gives rsp_sum=0x0000_0001_0000_0000. No wrap is hidden.

Flush
- rsp_valid <= 0 and no request is accepted that cycle.
- last_grant is unchanged.
- Flush wins over rsp_ready and over any grant.

Reset mid-operation
- A held result is lost and the slot returns to EMPTY immediately, independent of clk.

Fairness
- With both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1.

Protocol
- No grant when neither request is valid; last_grant is unchanged.
- Requesters must hold valid/a/b until ready is seen. The block does not check this.

Optional Feature:
- Macro BR_ARB_GRANT_CNT_EN.
- Defined:
  - gnt0_cnt/gnt1_cnt increment on each accepted transfer of the respective requester.
  - Saturate at all-ones.
  - Cleared by rst_n only; flush does not clear them.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, no requests -> rsp_valid=0, req0_ready=req1_ready=0, rsp_sum=0 for 5 cycles.
- req0 only, a=0x00001000, b=0x00000040, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x1040.
- Both valid every cycle, rsp_ready=1, a0=1/b0=1, a1=2/b1=2 -> results alternate id 0 sum 2, id 1 sum 4, one per cycle, starting with id 0.
- req0 a=0xFFFFFFFF b=0x1, rsp_ready=0 for 3 cycles then 1 -> rsp_sum=0x100000000 held stable, req0_ready=0 while held, released on the 4th cycle.
- Slot FULL, assert flush with rsp_ready=1 and req1_valid -> rsp_valid=0 next cycle, req1_ready=0 during flush, req1 accepted the following cycle.
- BR_ARB_GRANT_CNT_EN defined: 3 grants to req0, 2 to req1, then flush, then async rst_n pulse mid-transfer -> counts 3/2 survive flush, then 0/0 and rsp_valid=0 immediately on rst_n low.
